// File: rtl/mul_writeback_buffer.sv
// Writeback buffer between the multiplier and the register file.
// Circular FIFO of {flags, result, dest, set_cc} with condition-code update on retire.
module mul_writeback_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [35:0]              in_data,
    input  logic [4:0]               in_dest,
    input  logic                     in_set_cc,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic [4:0]               out_dest,
    output logic                     out_we,
    output logic [3:0]               cc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    logic [3:0]    flags_mem  [DEPTH];
    logic [31:0]   result_mem [DEPTH];
    logic [4:0]    dest_mem   [DEPTH];
    logic          set_cc_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [4:0]    head_dest;

    // Ready depends only on registered occupancy, so a full buffer never accepts on a pop cycle.
    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        head_dest  = dest_mem[rd_ptr];
        out_result = '0;
        out_dest   = '0;
        out_we     = 1'b0;
        if (out_valid) begin
            out_result = result_mem[rd_ptr];
            out_dest   = head_dest;
            out_we     = (head_dest != '0);
        end
    end

    // Storage is written only on an accepted push; no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            flags_mem[wr_ptr]  <= in_data[35:32];
            result_mem[wr_ptr] <= in_data[31:0];
            dest_mem[wr_ptr]   <= in_dest;
            set_cc_mem[wr_ptr] <= in_set_cc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cc         <= '0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
                if (set_cc_mem[rd_ptr]) begin
                    cc <= flags_mem[rd_ptr];
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_valid && !in_ready && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_writeback_buffer.sv
// Randomized bench for mul_writeback_buffer against a queue-based reference model.
module tb_mul_writeback_buffer;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        set_cc;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [35:0] in_data;
    logic [4:0]  in_dest;
    logic        in_set_cc;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        out_we;
    logic [3:0]  cc;
    logic [2:0]  count;
    logic [7:0]  drop_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    entry_t      model_q[$];
    logic [3:0]  model_cc;
    int unsigned model_drops;
    bit          model_known = 1'b0;

    mul_writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_set_cc  (in_set_cc),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dest   (out_dest),
        .out_we     (out_we),
        .cc         (cc),
        .count      (count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        entry_t head;
        bit     has;
        has  = (model_q.size() != 0);
        head = has ? model_q[0] : '0;
        check("out_valid",  64'(out_valid),  64'(has));
        check("in_ready",   64'(in_ready),   64'(model_q.size() < DEPTH));
        check("count",      64'(count),      64'(model_q.size()));
        check("out_result", 64'(out_result), has ? 64'(head.result) : 64'd0);
        check("out_dest",   64'(out_dest),   has ? 64'(head.dest) : 64'd0);
        check("out_we",     64'(out_we),     64'(has && head.dest != 5'd0));
        check("cc",         64'(cc),         64'(model_cc));
        check("drop_count", 64'(drop_count), 64'(model_drops));
    endtask

    // One clock cycle: apply inputs, check mid-cycle, then advance the model at the edge.
    task automatic cyc(input logic v, input logic [35:0] d, input logic [4:0] dst,
                       input logic sc, input logic ordy, input logic rst);
        bit     do_push;
        bit     do_pop;
        entry_t e;
        reset     = rst;
        in_valid  = v;
        in_data   = v ? d : 36'bz;
        in_dest   = dst;
        in_set_cc = sc;
        out_ready = ordy;
        #4;
        if (model_known) check_outputs();
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_cc    = 4'b0000;
            model_drops = 0;
            model_known = 1'b1;
        end else begin
            do_push = v && (model_q.size() < DEPTH);
            do_pop  = ordy && (model_q.size() != 0);
            if (v && !do_push && model_drops < 255) model_drops++;
            if (do_pop) begin
                if (model_q[0].set_cc) model_cc = model_q[0].flags;
                void'(model_q.pop_front());
            end
            if (do_push) begin
                e.flags  = d[35:32];
                e.result = d[31:0];
                e.dest   = dst;
                e.set_cc = sc;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic rand_push(input logic ordy);
        cyc(1'b1, {$urandom, $urandom}, 5'($urandom), 1'($urandom), ordy, 1'b0);
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, '0, '0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_dest = '0;
        in_set_cc = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // Single entry with cc update on retire.
        cyc(1'b1, {4'b1000, 32'hFFFF_FFFE}, 5'd3, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);
        check("cc_after_pop", 64'(cc), 64'(4'b1000));

        // Overfill by one.
        repeat (5) rand_push(1'b0);
        idle(1'b0);
        check("drop_after_overfill", 64'(drop_count), 64'd1);

        // Full with continuous push+pop across pointer wrap.
        repeat (10) rand_push(1'b1);
        repeat (5) idle(1'b1);

        // dest 0 entry: no write, no cc change.
        cyc(1'b1, {4'b0100, 32'h1234_5678}, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Reset beats a simultaneous push and pop.
        rand_push(1'b0);
        rand_push(1'b0);
        cyc(1'b1, {$urandom, $urandom}, 5'd7, 1'b1, 1'b1, 1'b1);
        idle(1'b0);

        // Drop counter saturation.
        repeat (4) rand_push(1'b0);
        repeat (300) rand_push(1'b0);
        idle(1'b0);
        check("drop_saturated", 64'(drop_count), 64'd255);

        // Random traffic with occasional resets.
        repeat (400) begin
            cyc(1'($urandom), {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                1'($urandom), ($urandom_range(0, 49) == 0));
        end
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mul_writeback_buffer.md
MUL_WRITEBACK_BUFFER -- requirements
Module: mul_writeback_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered entries; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: in_valid  input  1  upstream multiplier result valid this cycle.
REQ-005 Port: in_data  input  36  multiplier output packed {N[35], Z[34], C[33], V[32], result[31:0]}.
REQ-006 Port: in_dest  input  5  destination register index for the result.
REQ-007 Port: in_set_cc  input  1  entry updates the condition-code register when it retires.
REQ-008 Port: in_ready  output  1  buffer can accept an entry this cycle.
REQ-009 Port: out_valid  output  1  head entry present.
REQ-010 Port: out_ready  input  1  writeback consumes the head entry this cycle.
REQ-011 Port: out_result  output  32  head entry result.
REQ-012 Port: out_dest  output  5  head entry destination.
REQ-013 Port: out_we  output  1  register-file write enable for the head entry.
REQ-014 Port: cc  output  4  condition-code register {N,Z,C,V}.
REQ-015 Port: count  output  log2(DEPTH)+1  current occupancy.
REQ-016 Port: drop_count  output  8  saturating count of rejected push attempts.

Function
REQ-017 The block SHALL be a circular FIFO storing {flags[3:0], result[31:0], dest[4:0], set_cc} per entry.
REQ-018 A push SHALL occur when in_valid && in_ready; a pop when out_valid && out_ready.
REQ-019 in_ready SHALL be 1 exactly when count < DEPTH, derived from registered count only, with no dependence on out_ready.
REQ-020 out_valid SHALL be 1 exactly when count != 0.
REQ-021 out_result, out_dest, and out_we SHALL reflect the head entry combinationally from storage; while out_valid=0 they SHALL be 0.
REQ-022 out_we SHALL be out_valid && (out_dest != 0); entries with dest 0 SHALL still pop normally.
REQ-023 Latency: an entry pushed in cycle n SHALL appear at the outputs in cycle n+1 when the buffer was empty; there is no same-cycle bypass.
REQ-024 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-025 When full, in_ready=0, so no push occurs even if a pop occurs in the same cycle.
REQ-026 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 On a pop with set_cc=1, cc SHALL load the entry's flags on the same edge; otherwise cc SHALL hold.
REQ-028 in_data bits SHALL be ignored (not stored) whenever a push does not occur, including when they are undriven (z) while upstream is disabled.
REQ-029 drop_count SHALL increment by 1 each cycle where in_valid && !in_ready, and SHALL saturate at 255.
REQ-030 Stored entry contents SHALL never change between push and pop.

Reset
REQ-031 While reset=1 at a clock edge: count=0, both pointers=0, cc=4'b0000, drop_count=0; in the following cycle out_valid=0 and in_ready=1.
REQ-032 Reset SHALL take priority over any simultaneous push or pop; entries present before reset SHALL be discarded and never appear at the outputs.
REQ-033 Storage array contents need no reset.

Verification
REQ-034 Reset, then push {flags=4'b1000, result=32'hFFFF_FFFE, dest=3, set_cc=1} with out_ready=0 -> next cycle out_valid=1, out_result=FFFF_FFFE, out_we=1, cc=0000; after a pop -> cc=1000 and count=0.
REQ-035 DEPTH=4: push 5 consecutive entries with out_ready=0 -> in_ready=0 after the 4th push, 5th rejected, drop_count=1, count=4.
REQ-036 With 4 entries held, assert in_valid=out_ready=1 for 10 cycles -> pops occur, pushes refilled only after in_ready returns; output order matches push order across pointer wrap.
REQ-037 Push dest=0 with set_cc=0 and flags=0100 -> out_we=0 while valid; pop leaves cc unchanged.
REQ-038 Hold 2 entries, assert reset together with in_valid and out_ready -> next cycle count=0, out_valid=0, cc=0000, drop_count=0.
REQ-039 Hold in_valid=1 while full for 300 cycles -> drop_count saturates at 255.
